// File: rtl/gtype.sv
// Shared XGMII constants, framer state encoding and the terminate/IFG helper functions
// used by the 32-bit XGMII transmit framer.
package gtype;

  localparam logic [31:0] XGMII_IDLE   = 32'h0707_0707;
  localparam logic [7:0]  XGMII_IDLE_B = 8'h07;
  localparam logic [7:0]  XGMII_START  = 8'hFB;
  localparam logic [7:0]  XGMII_TERM   = 8'hFD;
  localparam logic [7:0]  XGMII_ERR    = 8'hFE;
  localparam logic [31:0] XGMII_PRE0   = {24'h55_5555, XGMII_START};
  localparam logic [31:0] XGMII_PRE1   = 32'hD555_5555;
  localparam logic [31:0] XGMII_TERM_W = {XGMII_IDLE_B, XGMII_IDLE_B, XGMII_IDLE_B, XGMII_TERM};
  localparam logic [31:0] XGMII_ERR_W  = {4{XGMII_ERR}};

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_TERM, ST_ABORT, ST_DRAIN, ST_IFG
  } framer_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic [2:0]  b;
  } term_t;

  typedef struct packed {
    logic [1:0] words;
    logic [1:0] dic;
  } ifg_plan_t;

  function automatic logic keep_valid(input logic [3:0] keep);
    return (keep == 4'b0001) || (keep == 4'b0011) || (keep == 4'b0111) || (keep == 4'b1111);
  endfunction

  // Partial last beat: FD goes in the first unused lane, idles above it.
  // b counts the control lanes of the terminate word (4 when a separate TERM word is needed).
  function automatic term_t term_encode(input logic [31:0] data, input logic [3:0] keep);
    term_t t;
    t.data = data;
    t.ctrl = 4'b0000;
    t.b    = 3'd4;
    case (keep)
      4'b0111: begin
        t.data = {XGMII_TERM, data[23:0]};
        t.ctrl = 4'b1000;
        t.b    = 3'd1;
      end
      4'b0011: begin
        t.data = {XGMII_IDLE_B, XGMII_TERM, data[15:0]};
        t.ctrl = 4'b1100;
        t.b    = 3'd2;
      end
      4'b0001: begin
        t.data = {XGMII_IDLE_B, XGMII_IDLE_B, XGMII_TERM, data[7:0]};
        t.ctrl = 4'b1110;
        t.b    = 3'd3;
      end
      default: ;
    endcase
    return t;
  endfunction

  // Deficit idle count: short gaps accumulate in dic until a third idle word pays it back.
  function automatic ifg_plan_t ifg_plan(input logic [1:0] dic, input logic [2:0] b);
    ifg_plan_t  p;
    logic [1:0] d;
    logic [2:0] sum;
    d       = 2'(3'd4 - b);
    sum     = {1'b0, dic} + {1'b0, d};
    p.words = (sum <= 3'd3) ? 2'd2 : 2'd3;
    p.dic   = sum[1:0];
    return p;
  endfunction

endpackage

// File: rtl/xgmii_tx_framer_32b.sv
// 32-bit XGMII transmit framer: adds start/preamble, terminate, deficit-idle IFG,
// and aborts frames on source underrun. All state advances only on ena=1 cycles.
module xgmii_tx_framer_32b
  import gtype::*;
(
  input  logic        clk_tx,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_keep,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        ena,
  output xgmii32_t    tx,
  output logic        err_underrun,
  output logic        err_keep
);

  framer_state_t r_state;
  framer_state_t w_state_next;
  logic [1:0]    r_dic;
  logic [1:0]    w_dic_next;
  logic [1:0]    r_ifg_cnt;
  logic [1:0]    w_ifg_cnt_next;
  xgmii32_t      r_tx;
  logic [31:0]   w_data_next;
  logic [3:0]    w_ctrl_next;
  logic          r_err_underrun;
  logic          r_err_keep;
  logic          w_err_underrun;
  logic          w_err_keep;
  term_t         w_term;
  logic          w_keep_ok;
  ifg_plan_t     w_plan_part;
  ifg_plan_t     w_plan_full;

  assign w_term      = term_encode(s_data, s_keep);
  assign w_keep_ok   = keep_valid(s_keep);
  assign w_plan_part = ifg_plan(r_dic, w_term.b);
  assign w_plan_full = ifg_plan(r_dic, 3'd4);

  assign s_ready      = ena && ((r_state == ST_DATA) || (r_state == ST_DRAIN));
  assign tx           = r_tx;
  assign err_underrun = r_err_underrun;
  assign err_keep     = r_err_keep;

  always_comb begin
    w_state_next   = r_state;
    w_dic_next     = r_dic;
    w_ifg_cnt_next = r_ifg_cnt;
    w_data_next    = XGMII_IDLE;
    w_ctrl_next    = 4'b1111;
    w_err_underrun = 1'b0;
    w_err_keep     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_data_next  = XGMII_PRE0;
          w_ctrl_next  = 4'b0001;
          w_state_next = ST_PRE;
        end
      end
      ST_PRE: begin
        w_data_next  = XGMII_PRE1;
        w_ctrl_next  = 4'b0000;
        w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (!s_valid) begin
          w_data_next    = XGMII_ERR_W;
          w_err_underrun = 1'b1;
          w_state_next   = ST_ABORT;
        end else if (!s_last) begin
          w_data_next = s_data;
          w_ctrl_next = 4'b0000;
        end else if (!w_keep_ok || (s_keep == 4'b1111)) begin
          // Illegal keep patterns are sent as a full beat.
          w_err_keep   = !w_keep_ok;
          w_data_next  = s_data;
          w_ctrl_next  = 4'b0000;
          w_state_next = ST_TERM;
        end else begin
          w_data_next    = w_term.data;
          w_ctrl_next    = w_term.ctrl;
          w_ifg_cnt_next = w_plan_part.words;
          w_dic_next     = w_plan_part.dic;
          w_state_next   = ST_IFG;
        end
      end
      ST_TERM: begin
        w_data_next    = XGMII_TERM_W;
        w_ifg_cnt_next = w_plan_full.words;
        w_dic_next     = w_plan_full.dic;
        w_state_next   = ST_IFG;
      end
      ST_ABORT: begin
        w_data_next  = XGMII_TERM_W;
        w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s_valid && s_last) begin
          w_ifg_cnt_next = w_plan_full.words;
          w_dic_next     = w_plan_full.dic;
          w_state_next   = ST_IFG;
        end
      end
      ST_IFG: begin
        w_ifg_cnt_next = r_ifg_cnt - 2'd1;
        if (r_ifg_cnt <= 2'd1) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_tx) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_dic          <= 2'd0;
      r_ifg_cnt      <= 2'd0;
      r_tx.data      <= XGMII_IDLE;
      r_tx.ctrl      <= 4'b1111;
      r_tx.ena       <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_keep     <= 1'b0;
    end else begin
      r_tx.ena       <= ena;
      r_err_underrun <= ena & w_err_underrun;
      r_err_keep     <= ena & w_err_keep;
      if (ena) begin
        r_state   <= w_state_next;
        r_dic     <= w_dic_next;
        r_ifg_cnt <= w_ifg_cnt_next;
        r_tx.data <= w_data_next;
        r_tx.ctrl <= w_ctrl_next;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer_32b.sv
// Scoreboard bench for the XGMII transmit framer: the driver queues one expected word per
// ena cycle, the monitor pops and compares every word the framer presents with tx.ena=1.
module tb_xgmii_tx_framer_32b;
  import gtype::*;

  logic        clk_tx = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = 4'hF;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        ena = 1'b1;
  logic        s_ready;
  xgmii32_t    tx;
  logic        err_underrun;
  logic        err_keep;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic stall_mode = 1'b0;
  logic ena_d;
  logic rst_d;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic        eu;
    logic        ek;
  } exp_t;
  exp_t q[$];

  always #5 clk_tx = ~clk_tx;

  xgmii_tx_framer_32b dut (
    .clk_tx(clk_tx), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .ena(ena), .tx(tx),
    .err_underrun(err_underrun), .err_keep(err_keep)
  );

  always @(posedge clk_tx) begin
    ena_d <= ena;
    rst_d <= rst;
  end

  always @(negedge clk_tx) begin
    exp_t e;
    if (rst_d === 1'b0) begin
      checks++;
      if (tx.ena !== ena_d) begin
        failures++;
        $display("FAIL tx_ena got=%b exp=%b", tx.ena, ena_d);
      end
      if (tx.ena === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%h/%b exp=none", tx.data, tx.ctrl);
        end else begin
          e = q.pop_front();
          if ({tx.data, tx.ctrl, err_underrun, err_keep} !== {e.d, e.c, e.eu, e.ek}) begin
            failures++;
            $display("FAIL tx_word got=%h/%b eu=%b ek=%b exp=%h/%b eu=%b ek=%b",
                     tx.data, tx.ctrl, err_underrun, err_keep, e.d, e.c, e.eu, e.ek);
          end else begin
            $display("word %h/%b eu=%b ek=%b", tx.data, tx.ctrl, err_underrun, err_keep);
          end
        end
      end else begin
        checks++;
        if ((err_underrun | err_keep) !== 1'b0) begin
          failures++;
          $display("FAIL err_in_stall got=%b%b exp=00", err_underrun, err_keep);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_tx);
    #1;
    cyc++;
  endtask

  // Queue one expected word for the next ena=1 cycle, holding inputs across stalls.
  task automatic emit(input logic [31:0] d, input logic [3:0] c, input logic eu, input logic ek);
    exp_t e;
    logic done;
    done = 1'b0;
    while (!done) begin
      ena = !(stall_mode && ((cyc % 33) == 32));
      if (ena) begin
        e.d = d; e.c = c; e.eu = eu; e.ek = ek;
        q.push_back(e);
        done = 1'b1;
      end else begin
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_in_stall got=%b exp=0", s_ready);
        end
      end
      step();
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) emit(XGMII_IDLE, 4'b1111, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] beat_data(input logic [7:0] seed, input int i);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = seed + 8'(4 * i + l);
    return d;
  endfunction

  task automatic put_beat(input logic [7:0] seed, input int i, input int nb,
                          input logic [3:0] kl, input logic ovr);
    s_valid = 1'b1;
    s_data  = (ovr && (i == nb - 1)) ? 32'hAABB_CCDD : beat_data(seed, i);
    s_last  = (i == nb - 1);
    s_keep  = (i == nb - 1) ? kl : 4'hF;
  endtask

  task automatic send_frame(input int nbytes, input logic [7:0] seed, input int ifg,
                            input int under_at, input logic bad_keep, input logic ovr,
                            input logic hold);
    int          nb;
    int          lastn;
    logic [3:0]  kl;
    logic [31:0] td;
    logic [3:0]  tc;
    logic        done;
    nb    = (nbytes + 3) / 4;
    lastn = nbytes - 4 * (nb - 1);
    kl    = bad_keep ? 4'b0101 : 4'((1 << lastn) - 1);
    $display("frame bytes=%0d ifg=%0d under_at=%0d bad_keep=%b", nbytes, ifg, under_at, bad_keep);
    put_beat(seed, 0, nb, kl, ovr);
    emit(XGMII_PRE0, 4'b0001, 1'b0, 1'b0);
    emit(XGMII_PRE1, 4'b0000, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < nb && !done; i++) begin
      put_beat(seed, i, nb, kl, ovr);
      if (i == under_at) begin
        s_valid = 1'b0;
        emit(32'hFEFE_FEFE, 4'b1111, 1'b1, 1'b0);
        s_valid = 1'b1;
        emit(32'h0707_07FD, 4'b1111, 1'b0, 1'b0);
        for (int j = i; j < nb; j++) begin
          put_beat(seed, j, nb, kl, ovr);
          emit(XGMII_IDLE, 4'b1111, 1'b0, 1'b0);
        end
        done = 1'b1;
      end else if (i < nb - 1) begin
        emit(s_data, 4'b0000, 1'b0, 1'b0);
      end else if (bad_keep || lastn == 4) begin
        emit(s_data, 4'b0000, 1'b0, bad_keep);
        s_valid = hold;
        emit(32'h0707_07FD, 4'b1111, 1'b0, 1'b0);
      end else begin
        case (lastn)
          3:       begin td = {8'hFD, s_data[23:0]};  tc = 4'b1000; end
          2:       begin td = {16'h07FD, s_data[15:0]}; tc = 4'b1100; end
          default: begin td = {24'h0707FD, s_data[7:0]}; tc = 4'b1110; end
        endcase
        if (ovr) td = 32'h07FD_CCDD;
        emit(td, tc, 1'b0, 1'b0);
      end
    end
    s_valid = hold;
    s_last  = 1'b0;
    repeat (ifg) emit(XGMII_IDLE, 4'b1111, 1'b0, 1'b0);
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if ({tx.data, tx.ctrl, tx.ena, s_ready, err_underrun, err_keep} !==
        {XGMII_IDLE, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s got=%h/%b ena=%b rdy=%b eu=%b ek=%b exp=07070707/1111 ena=0 rdy=0 eu=0 ek=0",
               name, tx.data, tx.ctrl, tx.ena, s_ready, err_underrun, err_keep);
    end else begin
      $display("reset %s ok", name);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b1;
    repeat (3) step();
    chk_reset("reset_initial");
    rst = 1'b0;
    idle(2);

    send_frame(64, 8'h00, 2, -1, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(61, 8'h10, 2, -1, 1'b0, 1'b0, 1'b1);
    send_frame(61, 8'h20, 2, -1, 1'b0, 1'b0, 1'b1);
    send_frame(61, 8'h30, 2, -1, 1'b0, 1'b0, 1'b1);
    send_frame(61, 8'h40, 3, -1, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(6, 8'h50, 2, -1, 1'b0, 1'b1, 1'b0);
    idle(2);
    send_frame(32, 8'h60, 2, 3, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(16, 8'h70, 2, -1, 1'b1, 1'b0, 1'b0);
    idle(2);

    stall_mode = 1'b1;
    cyc = 20;
    send_frame(64, 8'h80, 2, -1, 1'b0, 1'b0, 1'b0);
    send_frame(61, 8'h90, 2, -1, 1'b0, 1'b0, 1'b0);
    idle(2);
    stall_mode = 1'b0;

    put_beat(8'hA0, 0, 8, 4'hF, 1'b0);
    emit(XGMII_PRE0, 4'b0001, 1'b0, 1'b0);
    emit(XGMII_PRE1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      put_beat(8'hA0, i, 8, 4'hF, 1'b0);
      emit(s_data, 4'b0000, 1'b0, 1'b0);
    end
    rst = 1'b1;
    s_valid = 1'b0;
    ena = 1'b1;
    step();
    chk_reset("reset_mid_frame");
    rst = 1'b0;
    emit(XGMII_IDLE, 4'b1111, 1'b0, 1'b0);
    send_frame(61, 8'hB0, 2, -1, 1'b0, 1'b0, 1'b0);
    send_frame(63, 8'hC0, 3, -1, 1'b0, 1'b0, 1'b0);
    idle(4);

    ena = 1'b0;
    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_residue got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
